// File: rtl/cache_pkg.sv
// Shared types and constants for the write-back direct-mapped cache.
package cache_pkg;
  localparam int WORD_W        = 32;
  localparam int BLOCK_W       = 128;
  localparam int WORDS_PER_BLK = 4;
  localparam int MEM_ADDR_W    = 28;
  localparam int PROC_ADDR_W   = 30;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_t;

  // Single array write port: either a full-line fill or a one-word merge.
  typedef struct packed {
    logic               en;
    logic               fill;
    logic [1:0]         wsel;
    logic [WORD_W-1:0]  word;
    logic [BLOCK_W-1:0] line;
  } line_wr_t;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] line,
                                                 input logic [1:0] sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty/tag/data per line, async clear, one write port.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int INDEX_W    = 3,
  parameter int TAG_W      = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  line_wr_t           wr
);
  logic [NUM_BLOCKS-1:0]              valid_q, dirty_q;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]   tag_q;
  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] data_q;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_line
    // Per-line state: a fill installs a clean line, a merge dirties one word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end else if (wr.en && wr_idx == INDEX_W'(i)) begin
        if (wr.fill) begin
          valid_q[i] <= 1'b1;
          dirty_q[i] <= 1'b0;
          tag_q[i]   <= wr_tag;
          data_q[i]  <= wr.line;
        end else begin
          dirty_q[i] <= 1'b1;
          data_q[i][wr.wsel*WORD_W +: WORD_W] <= wr.word;
        end
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/wb_direct_cache.sv
// Direct-mapped write-back/write-allocate cache: hit compare plus miss FSM.
module wb_direct_cache
  import cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic                    clk,
  input  logic                    proc_reset,
  input  logic                    proc_read,
  input  logic                    proc_write,
  input  logic [PROC_ADDR_W-1:0]  proc_addr,
  input  logic [WORD_W-1:0]       proc_wdata,
  output logic [WORD_W-1:0]       proc_rdata,
  output logic                    proc_stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic [BLOCK_W-1:0]      mem_wdata,
  input  logic [BLOCK_W-1:0]      mem_rdata,
  input  logic                    mem_ready
);
  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = MEM_ADDR_W - INDEX_W;

  state_t                state, state_nxt;
  logic [MEM_ADDR_W-1:0] miss_addr;
  logic [INDEX_W-1:0]    req_idx, rd_idx, wr_idx;
  logic [TAG_W-1:0]      req_tag, line_tag, wr_tag;
  logic                  line_valid, line_dirty, req, hit, stall;
  logic [BLOCK_W-1:0]    line_data;
  line_wr_t              wr;

  assign req_idx = proc_addr[INDEX_W+1:2];
  assign req_tag = proc_addr[PROC_ADDR_W-1:INDEX_W+2];
  assign req     = proc_read | proc_write;
  // Outside IDLE the array is looked up with the latched miss block so a
  // dropped or changed request cannot redirect an in-flight transfer.
  assign rd_idx  = (state == S_IDLE) ? req_idx : miss_addr[INDEX_W-1:0];
  assign hit     = (state == S_IDLE) && line_valid && (line_tag == req_tag);

  cache_line_array #(.NUM_BLOCKS(NUM_BLOCKS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .rst      (proc_reset),
    .rd_idx   (rd_idx),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr       (wr)
  );

  assign proc_rdata = get_word(line_data, proc_addr[1:0]);
  assign proc_stall = stall & ~proc_reset;

  // State register and miss block latch.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state     <= S_IDLE;
      miss_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req && !hit)
        miss_addr <= proc_addr[PROC_ADDR_W-1:2];
    end
  end

  // Next-state, memory handshake and array write decode.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr        = '0;
    wr_idx    = req_idx;
    wr_tag    = req_tag;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            if (proc_write) begin
              wr.en   = 1'b1;
              wr.wsel = proc_addr[1:0];
              wr.word = proc_wdata;
            end
          end else begin
            stall     = 1'b1;
            state_nxt = (line_valid && line_dirty) ? S_WRITEBACK : S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {line_tag, miss_addr[INDEX_W-1:0]};
        mem_wdata = line_data;
        if (mem_ready) state_nxt = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        mem_addr = miss_addr;
        if (mem_ready) begin
          wr.en     = 1'b1;
          wr.fill   = 1'b1;
          wr.line   = mem_rdata;
          wr_idx    = miss_addr[INDEX_W-1:0];
          wr_tag    = miss_addr[MEM_ADDR_W-1:INDEX_W];
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule
